// File: rtl/memory_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_dump: streams a window of RAM words out over valid/ready after boot |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module memory_dump #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_boot_done,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_write_enable,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [ADDR_WIDTH-1:0] o_out_addr,
  output logic                  o_out_last
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam logic [ADDR_WIDTH:0]   c_rem_one  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic                  r_out_last;
  logic                  w_handshake;
  logic                  w_launch;

  assign w_handshake = r_out_valid & i_out_ready;
  assign w_launch    = i_start & i_boot_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            if (i_count != '0) begin
              r_cur_addr  <= i_base_addr;
              r_remaining <= i_count;
              r_state     <= S_ISSUE;
            end else begin
              r_state <= S_FINISH;
            end
          end
        end
        S_ISSUE: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          // Read data for r_cur_addr arrives one cycle after ISSUE presented it.
          r_out_data  <= i_mem_read_data;
          r_out_addr  <= r_cur_addr;
          r_out_last  <= (r_remaining == c_rem_one);
          r_out_valid <= 1'b1;
          r_state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_remaining <= r_remaining - c_rem_one;
            r_cur_addr  <= r_cur_addr + c_addr_one;
            r_state     <= r_out_last ? S_FINISH : S_ISSUE;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy             = (r_state == S_ISSUE) || (r_state == S_CAPTURE) ||
                              (r_state == S_PRESENT);
  assign o_done             = (r_state == S_FINISH);
  assign o_mem_write_enable = 1'b0;
  assign o_mem_write_data   = '0;
  assign o_mem_addr         = r_cur_addr;
  assign o_out_valid        = r_out_valid;
  assign o_out_data         = r_out_data;
  assign o_out_addr         = r_out_addr;
  assign o_out_last         = r_out_last;

endmodule
`default_nettype wire
